pc_register_stack: RTL

- Parametrised program-counter register. It generalises the single async-reset D flip-flop with complementary outputs to a WIDTH-bit register with a configurable reset value.
- Supports stall, increment, absolute jump, relative branch, and call/return through a DEPTH-entry return-address stack.
- Sits between the fetch stage and the instruction memory address port of the single-cycle CPU.

---
 rtl/pc_register_stack.sv | 125 ++++++++++++
 1 files changed

// File: rtl/pc_register_stack.sv
// Program-counter register with stall, jump, branch and call/return.
// Ports: CLK/RST async reset, ENA stall, JUMP/BRANCH/CALL/RET ops,
//   TARGET/OFFSET operands, ERR_CLR; outputs PC, PC_n, SP, FULL,
//   EMPTY, ERR (sticky stack overflow/underflow).
module pc_register_stack #(
   parameter int unsigned      WIDTH       = 32,
   parameter logic [WIDTH-1:0] RESET_VALUE = '0,
   parameter int unsigned      STEP        = 4,
   parameter int unsigned      DEPTH       = 4
) (
   input  logic                       CLK,
   input  logic                       RST,
   input  logic                       ENA,
   input  logic                       JUMP,
   input  logic                       BRANCH,
   input  logic                       CALL,
   input  logic                       RET,
   input  logic [WIDTH-1:0]           TARGET,
   input  logic [15:0]                OFFSET,
   input  logic                       ERR_CLR,
   output logic [WIDTH-1:0]           PC,
   output logic [WIDTH-1:0]           PC_n,
   output logic [$clog2(DEPTH):0]     SP,
   output logic                       FULL,
   output logic                       EMPTY,
   output logic                       ERR
);

   localparam int AW = $clog2(DEPTH);
   localparam int SW = AW + 1;

   logic [WIDTH-1:0] r_pc;
   logic [WIDTH-1:0] r_pc_n;
   logic [SW-1:0]    r_sp;
   logic             r_err;
   logic [WIDTH-1:0] r_stack [DEPTH];

   logic [WIDTH-1:0] w_pc_nxt;
   logic [SW-1:0]    w_sp_nxt;
   logic             w_push;
   logic             w_err_set;
   logic             w_full;
   logic             w_empty;
   logic [AW-1:0]    w_rd_idx;
   logic [AW-1:0]    w_wr_idx;
   logic [WIDTH-1:0] w_off;
   logic [WIDTH-1:0] w_step;
   logic [SW-1:0]    w_sp_dec;

   assign w_full   = (r_sp == SW'(DEPTH));
   assign w_empty  = (r_sp == '0);
   assign w_sp_dec = r_sp - 1'b1;
   assign w_rd_idx = w_sp_dec[AW-1:0];
   assign w_wr_idx = r_sp[AW-1:0];
   // Signed cast before resize gives sign extension to WIDTH.
   assign w_off    = WIDTH'($signed(OFFSET));
   assign w_step   = WIDTH'(STEP);

   // Fixed priority: RET > CALL > JUMP > BRANCH > increment.
   always_comb begin
      w_pc_nxt  = r_pc;
      w_sp_nxt  = r_sp;
      w_push    = 1'b0;
      w_err_set = 1'b0;
      if (ENA) begin
         if (RET) begin
            if (w_empty) begin
               w_err_set = 1'b1;
            end else begin
               w_pc_nxt = r_stack[w_rd_idx];
               w_sp_nxt = w_sp_dec;
            end
         end else if (CALL) begin
            if (w_full) begin
               w_err_set = 1'b1;
            end else begin
               w_push   = 1'b1;
               w_pc_nxt = TARGET;
               w_sp_nxt = r_sp + 1'b1;
            end
         end else if (JUMP) begin
            w_pc_nxt = TARGET;
         end else if (BRANCH) begin
            w_pc_nxt = r_pc + w_off;
         end else begin
            w_pc_nxt = r_pc + w_step;
         end
      end
   end

   always_ff @(posedge CLK or posedge RST) begin
      if (RST) begin
         r_pc   <= RESET_VALUE;
         r_pc_n <= ~RESET_VALUE;
         r_sp   <= '0;
         r_err  <= 1'b0;
      end else begin
         r_pc   <= w_pc_nxt;
         r_pc_n <= ~w_pc_nxt;
         r_sp   <= w_sp_nxt;
         // A set in the same cycle as a clear wins.
         if (w_err_set)
            r_err <= 1'b1;
         else if (ERR_CLR)
            r_err <= 1'b0;
      end
   end

   always_ff @(posedge CLK or posedge RST) begin
      if (RST) begin
         for (int i = 0; i < DEPTH; i++)
            r_stack[i] <= '0;
      end else if (w_push) begin
         r_stack[w_wr_idx] <= r_pc + w_step;
      end
   end

   assign PC    = r_pc;
   assign PC_n  = r_pc_n;
   assign SP    = r_sp;
   assign FULL  = w_full;
   assign EMPTY = w_empty;
   assign ERR   = r_err;

endmodule
